// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate format encoding for the immediate generator.
package imm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: instruction word -> sign-extended immediate and format.
// The illegal_o port exists only when IMMGEN_ILLEGAL_EN is defined.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o
`ifdef IMMGEN_ILLEGAL_EN
    ,
    output logic            illegal_o
`endif
);

    logic [31:0] imm32;

    always_comb begin
        fmt_o = FMT_NONE;
`ifdef IMMGEN_ILLEGAL_EN
        illegal_o = 1'b0;
`endif
        case (inst_i[6:0])
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: fmt_o = FMT_I;
            OP_STORE:                                      fmt_o = FMT_S;
            OP_BRANCH:                                     fmt_o = FMT_B;
            OP_LUI, OP_AUIPC:                              fmt_o = FMT_U;
            OP_JAL:                                        fmt_o = FMT_J;
            OP_OP, OP_OP32, OP_FENCE:                      fmt_o = FMT_NONE;
            default: begin
                fmt_o = FMT_NONE;
`ifdef IMMGEN_ILLEGAL_EN
                illegal_o = 1'b1;
`endif
            end
        endcase
    end

    // Fields are assembled already sign-extended to 32 bits; bit 31 is inst[31] for every format.
    always_comb begin
        imm32 = '0;
        case (fmt_o)
            FMT_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                            inst_i[11:8], 1'b0};
            FMT_U: imm32 = {inst_i[31:12], 12'b0};
            FMT_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                            inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_o       = {XLEN{imm32[31]}};
        imm_o[31:0] = imm32;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one decoder feeding a DEPTH-entry result FIFO with valid/ready.
// Optional per-entry illegal-opcode flag on o_err when IMMGEN_ILLEGAL_EN is defined.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("imm_gen_pipe: DEPTH must be at least 1");
    end

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;

    logic [XLEN-1:0]  imm_mem_q [DEPTH];
    imm_fmt_e         fmt_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q;
    logic             push, pop;

`ifdef IMMGEN_ILLEGAL_EN
    logic             dec_illegal;
    logic             err_mem_q [DEPTH];
`endif

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .inst_i    (i_inst),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt)
`ifdef IMMGEN_ILLEGAL_EN
        ,
        .illegal_o (dec_illegal)
`endif
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push = i_valid && ready_q;
    assign pop  = o_valid && i_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
    end

    // ready is registered from the next count, so a pop while full reopens it one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d < CNT_W'(DEPTH));
            if (push)
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            imm_mem_q[wr_ptr_q] <= dec_imm;
            fmt_mem_q[wr_ptr_q] <= dec_fmt;
            tag_mem_q[wr_ptr_q] <= i_tag;
`ifdef IMMGEN_ILLEGAL_EN
            err_mem_q[wr_ptr_q] <= dec_illegal;
`endif
        end
    end

    // Storage is not reset; outputs are masked so an empty FIFO always presents zeros.
    assign o_ready = ready_q;
    assign o_valid = (count_q != '0);
    assign o_imm   = o_valid ? imm_mem_q[rd_ptr_q] : '0;
    assign o_fmt   = o_valid ? fmt_mem_q[rd_ptr_q] : FMT_NONE;
    assign o_tag   = o_valid ? tag_mem_q[rd_ptr_q] : '0;
`ifdef IMMGEN_ILLEGAL_EN
    assign o_err   = o_valid ? err_mem_q[rd_ptr_q] : 1'b0;
`else
    assign o_err   = 1'b0;
`endif

endmodule
